uldl_packet_serializer: RTL and testbench

Downstream stage of the UL/DL traffic generator. It captures each single-cycle packet strobe (8-bit packet ID plus direction flag) into a small FIFO. It then serializes queued packets onto a 1-bit UART-like link toward the satellite-link pin, and keeps per-direction accepted and dropped packet statistics.

---
 rtl/uldl_packet_serializer_if.sv | 16 +
 rtl/uldl_packet_serializer.sv | 179 +++++++++++++++++
 tb/tb_uldl_packet_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uldl_packet_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uldl_packet_serializer_if
//  Description : Packet strobe bundle (pulse, ID, direction) feeding the
//                UL/DL packet serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uldl_packet_serializer_if;
    logic       i_packet_pulse;
    logic [7:0] i_packet_id;
    logic       i_dir_dl;

    modport master (output i_packet_pulse, i_packet_id, i_dir_dl);
    modport slave  (input  i_packet_pulse, i_packet_id, i_dir_dl);
endinterface
`default_nettype wire

// File: rtl/uldl_packet_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uldl_packet_serializer
//  Description : Queues packet strobes in a FIFO and serializes them LSB-first
//                onto a UART-like line with per-direction statistics.
//                Define TX_PARITY_EN to add an even-parity bit before stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uldl_packet_serializer #(
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    uldl_packet_serializer_if.slave pkt,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic [$clog2(DEPTH):0]  o_fifo_level,
    output logic [7:0]              o_ul_count,
    output logic [7:0]              o_dl_count,
    output logic [7:0]              o_drop_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = $clog2(BIT_DIV + 1);
`ifdef TX_PARITY_EN
    localparam int c_FRAME_BITS = 12;
`else
    localparam int c_FRAME_BITS = 11;
`endif
    localparam int c_BW = $clog2(c_FRAME_BITS);

    localparam logic [c_LW-1:0] c_FULL_LVL = c_LW'(DEPTH);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(BIT_DIV - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FRAME_BITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [8:0]              r_mem [DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_LW-1:0]         r_level;
    logic [7:0]              r_ul_cnt;
    logic [7:0]              r_dl_cnt;
    logic [7:0]              r_drop_cnt;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_DW-1:0]         r_div;
    logic [c_BW-1:0]         r_bit;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_push_req;
    logic                    w_push_ok;
    logic                    w_pop;
    logic                    w_div_last;
    logic                    w_frame_end;
    logic [8:0]              w_head;
    logic [c_FRAME_BITS-1:0] w_frame;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_FULL_LVL);
    assign w_push_req  = ena && pkt.i_packet_pulse;
    // A full FIFO still accepts when the serializer pops in the same cycle.
    assign w_push_ok   = w_push_req && (!w_full || w_pop);
    assign w_div_last  = (r_div == c_DIV_LAST);
    assign w_frame_end = w_div_last && (r_bit == c_BIT_LAST);
    assign w_head      = r_mem[r_rd_ptr];

`ifdef TX_PARITY_EN
    assign w_frame = {1'b1, ^w_head, w_head[7:0], w_head[8], 1'b0};
`else
    assign w_frame = {1'b1, w_head[7:0], w_head[8], 1'b0};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        o_tx        = 1'b1;
        o_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ena && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_tx   = r_shift[0];
                o_busy = 1'b1;
                if (ena && w_frame_end) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {pkt.i_dir_dl, pkt.i_packet_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ul_cnt   <= '0;
            r_dl_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
                if (pkt.i_dir_dl) r_dl_cnt <= r_dl_cnt + 8'd1;
                else              r_ul_cnt <= r_ul_cnt + 8'd1;
            end else if (w_push_req && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_div   <= '0;
            r_bit   <= '0;
        end else if (ena) begin
            if (w_pop) begin
                r_shift <= w_frame;
                r_div   <= '0;
                r_bit   <= '0;
            end else if (r_state == ST_SHIFT) begin
                if (w_div_last) begin
                    r_div   <= '0;
                    r_bit   <= r_bit + c_BW'(1);
                    r_shift <= {1'b1, r_shift[c_FRAME_BITS-1:1]};
                end else begin
                    r_div <= r_div + c_DW'(1);
                end
            end
        end
    end

    assign o_fifo_level = r_level;
    assign o_ul_count   = r_ul_cnt;
    assign o_dl_count   = r_dl_cnt;
    assign o_drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uldl_packet_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uldl_packet_serializer
//  Description : Directed self-checking bench for uldl_packet_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uldl_packet_serializer;

    localparam int DEPTH   = 4;
    localparam int BIT_DIV = 4;
`ifdef TX_PARITY_EN
    localparam int FB = 12;
`else
    localparam int FB = 11;
`endif
    localparam int FRAME_CYC = FB * BIT_DIV;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       tx;
    logic       busy;
    logic [2:0] level;
    logic [7:0] ul_cnt;
    logic [7:0] dl_cnt;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    uldl_packet_serializer_if pif ();

    uldl_packet_serializer #(
        .DEPTH   (DEPTH),
        .BIT_DIV (BIT_DIV)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .pkt          (pif),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_level (level),
        .o_ul_count   (ul_cnt),
        .o_dl_count   (dl_cnt),
        .o_drop_count (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for frame bit b (start, dir, id LSB first, [parity], stop).
    function automatic logic fbit(input int b, input logic [7:0] id, input logic dir);
        if (b == 0) return 1'b0;
        if (b == 1) return dir;
        if (b <= 9) return id[b-2];
`ifdef TX_PARITY_EN
        if (b == 10) return ^{dir, id};
`endif
        return 1'b1;
    endfunction

    task automatic check_part(input logic [7:0] id, input logic dir, input int t0, input int t1);
        for (int t = t0; t < t1; t++) begin
            check($sformatf("tx_bit%0d", t / BIT_DIV), tx, fbit(t / BIT_DIV, id, dir));
            check("busy_frame", busy, 1);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single strobe from idle; returns aligned on the first cycle of the start bit.
    task automatic send_one(input logic [7:0] id, input logic dir);
        pif.i_packet_pulse = 1'b1;
        pif.i_packet_id    = id;
        pif.i_dir_dl       = dir;
        @(negedge clk);
        pif.i_packet_pulse = 1'b0;
        check("level_after_push", level, 1);
        check("tx_idle_before_pop", tx, 1);
        @(negedge clk);
        check("level_after_pop", level, 0);
    endtask

    // n strobes on consecutive cycles, then verify accepted frames back-to-back.
    task automatic burst(input int n);
        int acc;
        int exp_ul;
        int exp_dl;
        acc    = (n < DEPTH + 1) ? n : DEPTH + 1;
        exp_ul = 0;
        exp_dl = 0;
        for (int i = 0; i < n; i++) begin
            pif.i_packet_pulse = 1'b1;
            pif.i_packet_id    = 8'(8'h1D * (i + 1));
            pif.i_dir_dl       = i[0];
            @(negedge clk);
            check($sformatf("burst%0d_level_i%0d", n, i), level,
                  (i == 0) ? 1 : ((i < DEPTH) ? i : DEPTH));
            if (i < acc) begin
                if (i[0]) exp_dl++;
                else      exp_ul++;
            end
        end
        pif.i_packet_pulse = 1'b0;
        check_part(8'h1D, 1'b0, n - 2, FRAME_CYC);
        for (int k = 1; k < acc; k++) begin
            check($sformatf("burst%0d_level_k%0d", n, k), level, acc - 1 - k);
            check_part(8'(8'h1D * (k + 1)), k[0], 0, FRAME_CYC);
        end
        check("burst_tx_idle", tx, 1);
        check("burst_busy_idle", busy, 0);
        check("burst_level_end", level, 0);
        check("burst_drop", drop_cnt, n - acc);
        check("burst_ul", ul_cnt, exp_ul);
        check("burst_dl", dl_cnt, exp_dl);
    endtask

    initial begin
        rst_n              = 1'b0;
        ena                = 1'b1;
        pif.i_packet_pulse = 1'b0;
        pif.i_packet_id    = 8'h00;
        pif.i_dir_dl       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ul", ul_cnt, 0);
        check("rst_dl", dl_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single UL packet 0xA5
        send_one(8'hA5, 1'b0);
        check_part(8'hA5, 1'b0, 0, FRAME_CYC);
        check("single_tx_idle", tx, 1);
        check("single_busy", busy, 0);
        check("single_ul", ul_cnt, 1);
        check("single_dl", dl_cnt, 0);

        do_reset();
        burst(5);
        do_reset();
        burst(8);

        // Alternating directions, 100 cycles apart
        do_reset();
        for (int p = 0; p < 10; p++) begin
            send_one(8'(8'h40 + p), p[0]);
            check_part(8'(8'h40 + p), p[0], 0, FRAME_CYC);
            repeat (100 - 2 - FRAME_CYC) @(negedge clk);
        end
        check("alt_ul", ul_cnt, 5);
        check("alt_dl", dl_cnt, 5);
        check("alt_drop", drop_cnt, 0);

        // ena low for 20 cycles mid-frame with an ignored strobe
        do_reset();
        send_one(8'h5A, 1'b1);
        check_part(8'h5A, 1'b1, 0, 20);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pif.i_packet_pulse = (i == 5);
            pif.i_packet_id    = 8'hEE;
            pif.i_dir_dl       = 1'b0;
            @(negedge clk);
            check("frz_tx", tx, fbit(20 / BIT_DIV, 8'h5A, 1'b1));
            check("frz_busy", busy, 1);
            check("frz_level", level, 0);
            check("frz_ul", ul_cnt, 0);
            check("frz_drop", drop_cnt, 0);
        end
        pif.i_packet_pulse = 1'b0;
        ena = 1'b1;
        check_part(8'h5A, 1'b1, 20, FRAME_CYC);
        check("frz_end_busy", busy, 0);
        check("frz_end_level", level, 0);
        check("frz_end_dl", dl_cnt, 1);
        check("frz_end_ul", ul_cnt, 0);
        check("frz_end_drop", drop_cnt, 0);

        // Asynchronous reset during the 5th bit with one entry queued
        do_reset();
        send_one(8'h3A, 1'b0);
        check_part(8'h3A, 1'b0, 0, 8);
        pif.i_packet_pulse = 1'b1;
        pif.i_packet_id    = 8'h77;
        pif.i_dir_dl       = 1'b1;
        check_part(8'h3A, 1'b0, 8, 9);
        pif.i_packet_pulse = 1'b0;
        check("mid_level", level, 1);
        check_part(8'h3A, 1'b0, 9, 17);
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        check("arst_ul", ul_cnt, 0);
        check("arst_dl", dl_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_rst_tx", tx, 1);
            check("post_rst_busy", busy, 0);
        end
        check("post_rst_level", level, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
